// File: rtl/vae_seq_pkg.sv
// Shared definitions for the VAE layer sequencer: state encoding, stage indices
// and default stage count.
package vae_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_RUN   = 2'd2,
        S_LATCH = 2'd3
    } seq_state_t;

    localparam int unsigned DEFAULT_NUM_STAGES = 5;
    localparam int unsigned IDX_W              = 3;

    localparam logic [IDX_W-1:0] ST_ENC1   = 3'd0;
    localparam logic [IDX_W-1:0] ST_ENC2   = 3'd1;
    localparam logic [IDX_W-1:0] ST_LAMBDA = 3'd2;
    localparam logic [IDX_W-1:0] ST_DEC1   = 3'd3;
    localparam logic [IDX_W-1:0] ST_DEC2   = 3'd4;

endpackage

// File: rtl/vae_layer_sequencer_next_stage.sv
// Combinational priority finder: lowest enabled stage above the current index,
// or the lowest enabled stage overall when from_start is set.
module vae_next_stage
    import vae_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEFAULT_NUM_STAGES
) (
    input  logic [NUM_STAGES-1:0] mask,
    input  logic [IDX_W-1:0]      cur,
    input  logic                  from_start,
    output logic [IDX_W-1:0]      next_idx,
    output logic                  valid
);

    logic [NUM_STAGES-1:0] cand;

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_cand
            assign cand[gi] = mask[gi] && (from_start || (IDX_W'(gi) > cur));
        end
    endgenerate

    // Scan downwards so the lowest candidate is the last one written.
    always_comb begin
        next_idx = '0;
        valid    = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (cand[i]) begin
                next_idx = IDX_W'(i);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vae_layer_sequencer.sv
// Steps the VAE compute stages through reset/release/done/latch in mask order.
// Optional RUN-state watchdog enabled by defining WATCHDOG_EN.
module vae_layer_sequencer
    import vae_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = DEFAULT_NUM_STAGES,
    parameter int unsigned RST_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_STAGES-1:0] run_mask,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic [NUM_STAGES-1:0] stage_latch,
    output logic [2:0]            cur_stage,
    output logic                  busy,
    output logic                  done_all,
    output logic                  error
);

    localparam int unsigned CNT_W = $clog2(RST_CYCLES) + 1;

    seq_state_t            state_reg, state_next;
    logic [IDX_W-1:0]      cur_reg, cur_next;
    logic [NUM_STAGES-1:0] mask_reg, mask_next;
    logic [NUM_STAGES-1:0] stage_rst_reg, stage_rst_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  done_all_reg, done_all_next;

    logic [NUM_STAGES-1:0] finder_mask;
    logic [IDX_W-1:0]      finder_idx;
    logic                  finder_valid;
    logic                  from_start;

    // One finder serves both the first-stage pick (live run_mask) and the advance.
    assign from_start  = (state_reg == S_IDLE);
    assign finder_mask = from_start ? run_mask : mask_reg;

    vae_next_stage #(
        .NUM_STAGES (NUM_STAGES)
    ) u_next_stage (
        .mask       (finder_mask),
        .cur        (cur_reg),
        .from_start (from_start),
        .next_idx   (finder_idx),
        .valid      (finder_valid)
    );

`ifdef WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic            error_reg, error_next;
`endif

    always_comb begin
        state_next     = state_reg;
        cur_next       = cur_reg;
        mask_next      = mask_reg;
        stage_rst_next = stage_rst_reg;
        cnt_next       = cnt_reg;
        done_all_next  = done_all_reg;
`ifdef WATCHDOG_EN
        wd_cnt_next    = wd_cnt_reg;
        error_next     = error_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    mask_next      = run_mask;
                    stage_rst_next = '1;
                    cnt_next       = '0;
`ifdef WATCHDOG_EN
                    error_next     = 1'b0;
`endif
                    if (finder_valid) begin
                        state_next    = S_ARM;
                        cur_next      = finder_idx;
                        done_all_next = 1'b0;
                    end else begin
                        done_all_next = 1'b1;
                    end
                end
            end
            S_ARM: begin
                if (cnt_reg == CNT_W'(RST_CYCLES - 1)) begin
                    state_next              = S_RUN;
                    cnt_next                = '0;
                    stage_rst_next[cur_reg] = 1'b0;
`ifdef WATCHDOG_EN
                    wd_cnt_next             = '0;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_RUN: begin
                if (stage_done[cur_reg]) begin
                    state_next = S_LATCH;
`ifdef WATCHDOG_EN
                end else if (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next     = S_IDLE;
                    cur_next       = '0;
                    stage_rst_next = '1;
                    error_next     = 1'b1;
                end else begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
`endif
                end
            end
            S_LATCH: begin
                if (finder_valid) begin
                    state_next = S_ARM;
                    cur_next   = finder_idx;
                    cnt_next   = '0;
                end else begin
                    state_next    = S_IDLE;
                    cur_next      = '0;
                    done_all_next = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            cur_reg       <= '0;
            mask_reg      <= '0;
            stage_rst_reg <= '1;
            cnt_reg       <= '0;
            done_all_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_reg       <= cur_next;
            mask_reg      <= mask_next;
            stage_rst_reg <= stage_rst_next;
            cnt_reg       <= cnt_next;
            done_all_reg  <= done_all_next;
        end
    end

`ifdef WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_reg <= '0;
            error_reg  <= 1'b0;
        end else begin
            wd_cnt_reg <= wd_cnt_next;
            error_reg  <= error_next;
        end
    end
    assign error = error_reg;
`else
    assign error = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_latch
            assign stage_latch[gi] = (state_reg == S_LATCH) && (cur_reg == IDX_W'(gi));
        end
    endgenerate

    assign stage_rst = stage_rst_reg;
    assign cur_stage = (state_reg == S_IDLE) ? 3'd0 : cur_reg;
    assign busy      = (state_reg != S_IDLE);
    assign done_all  = done_all_reg;

endmodule

// File: tb/tb_vae_layer_sequencer.sv
// Directed bench for vae_layer_sequencer with a simple layer model that raises
// done three cycles after a stage is released from reset.
module tb_vae_layer_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] run_mask = '0;
    logic [4:0] stage_done = '0;
    logic [4:0] stage_rst;
    logic [4:0] stage_latch;
    logic [2:0] cur_stage;
    logic       busy;
    logic       done_all;
    logic       error;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int sc       = 0;
    int run_cnt[5];
    logic [4:0] never_done = '0;

    logic [4:0] lat_q[$];
    int         lat_cyc_q[$];
    logic [2:0] lat_cur_q[$];

    vae_layer_sequencer #(
        .NUM_STAGES     (5),
        .RST_CYCLES     (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .run_mask    (run_mask),
        .stage_done  (stage_done),
        .stage_rst   (stage_rst),
        .stage_latch (stage_latch),
        .cur_stage   (cur_stage),
        .busy        (busy),
        .done_all    (done_all),
        .error       (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        else begin
            n_pass++;
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Layer model: done rises on the third cycle after release.
    initial begin
        for (int i = 0; i < 5; i++) run_cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                if (stage_rst[i]) run_cnt[i] = 0;
                else if (run_cnt[i] < 1000) run_cnt[i] = run_cnt[i] + 1;
                stage_done[i] = (run_cnt[i] >= 3) && !never_done[i];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (stage_latch != 5'd0) begin
                lat_q.push_back(stage_latch);
                lat_cyc_q.push_back(cyc);
                lat_cur_q.push_back(cur_stage);
            end
        end
    end

    task automatic clear_log();
        lat_q.delete();
        lat_cyc_q.delete();
        lat_cur_q.delete();
    endtask

    // Leaves sc = cycle stamp of the first negedge after start is accepted.
    task automatic do_start(input logic [4:0] m);
        @(negedge clk);
        start    = 1'b1;
        run_mask = m;
        @(negedge clk);
        start = 1'b0;
        sc    = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) check_val("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Expected: one pulse per enabled stage, ascending, 6 cycles apart.
    task automatic expect_latches(input string tag, input logic [4:0] m, input int base);
        int k;
        logic [4:0] one;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            if (m[i]) begin
                one = 5'd1 << i;
                if (k < lat_q.size()) begin
                    check_val({tag, "_latch_vec"}, 32'(lat_q[k]), 32'(one));
                    check_val({tag, "_latch_cyc"}, 32'(lat_cyc_q[k]), 32'(base + 5 + 6 * k));
                    check_val({tag, "_latch_cur"}, 32'(lat_cur_q[k]), 32'(i));
                end
                k++;
            end
        end
        check_val({tag, "_latch_count"}, 32'(lat_q.size()), 32'(k));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_stage_rst", 32'(stage_rst), 32'h1f);
        check_val("rst_latch", 32'(stage_latch), 32'h0);
        check_val("rst_cur", 32'(cur_stage), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_done_all", 32'(done_all), 32'h0);
        check_val("rst_error", 32'(error), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Full run
        clear_log();
        do_start(5'b11111);
        check_val("full_busy_after_start", 32'(busy), 32'h1);
        check_val("full_done_all_cleared", 32'(done_all), 32'h0);
        wait_idle(200);
        expect_latches("full", 5'b11111, sc);
        check_val("full_done_all", 32'(done_all), 32'h1);
        check_val("full_stage_rst", 32'(stage_rst), 32'h00);
        check_val("full_error", 32'(error), 32'h0);

        // Skip stages 1,3,4
        clear_log();
        do_start(5'b00101);
        check_val("skip_stage_rst_rearmed", 32'(stage_rst), 32'h1f);
        wait_idle(200);
        expect_latches("skip", 5'b00101, sc);
        check_val("skip_stage_rst", 32'(stage_rst), 32'h1a);
        check_val("skip_done_all", 32'(done_all), 32'h1);

        // Empty mask
        clear_log();
        do_start(5'b00000);
        check_val("empty_busy", 32'(busy), 32'h0);
        check_val("empty_done_all", 32'(done_all), 32'h1);
        check_val("empty_stage_rst", 32'(stage_rst), 32'h1f);
        repeat (4) @(negedge clk);
        check_val("empty_busy_later", 32'(busy), 32'h0);
        check_val("empty_latch_count", 32'(lat_q.size()), 32'h0);

        // Second start and mask change while busy
        clear_log();
        do_start(5'b11111);
        repeat (8) @(negedge clk);
        start    = 1'b1;
        run_mask = 5'b00001;
        @(negedge clk);
        start    = 1'b0;
        run_mask = 5'b00000;
        wait_idle(200);
        expect_latches("busy_start", 5'b11111, sc);
        @(negedge clk);
        check_val("busy_start_idle", 32'(busy), 32'h0);

        // Reset during RUN of idx 2, with start asserted alongside
        clear_log();
        do_start(5'b11111);
        begin
            int n;
            n = 0;
            while (!(cur_stage == 3'd2 && stage_rst[2] == 1'b0) && n < 100) begin
                @(negedge clk);
                n++;
            end
            check_val("midrst_reached_run2", 32'(cur_stage == 3'd2 && stage_rst[2] == 1'b0), 32'h1);
        end
        reset    = 1'b1;
        start    = 1'b1;
        run_mask = 5'b11111;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check_val("midrst_stage_rst", 32'(stage_rst), 32'h1f);
        check_val("midrst_busy", 32'(busy), 32'h0);
        check_val("midrst_done_all", 32'(done_all), 32'h0);
        check_val("midrst_latch", 32'(stage_latch), 32'h0);
        repeat (3) @(negedge clk);
        check_val("midrst_latch_count", 32'(lat_q.size()), 32'h2);
        check_val("midrst_busy_later", 32'(busy), 32'h0);

`ifdef WATCHDOG_EN
        // idx 1 never completes
        clear_log();
        never_done = 5'b00010;
        do_start(5'b00011);
        wait_idle(200);
        check_val("wd_idle_cyc", 32'(cyc), 32'(sc + 24));
        check_val("wd_error", 32'(error), 32'h1);
        check_val("wd_stage_rst", 32'(stage_rst), 32'h1f);
        check_val("wd_done_all", 32'(done_all), 32'h0);
        check_val("wd_latch_count", 32'(lat_q.size()), 32'h1);
        never_done = 5'b00000;
        do_start(5'b00001);
        check_val("wd_error_cleared", 32'(error), 32'h0);
        wait_idle(200);
        check_val("wd_recover_done_all", 32'(done_all), 32'h1);
`else
        check_val("no_wd_error", 32'(error), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
